qr_motion_ctrl: RTL

//  Frame-synchronous motion scheduler for up to NUM_SPRITES bouncing QR sprites on the 640x480 VGA path.

---
 rtl/qr_motion_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/qr_motion_ctrl.sv
// qr_motion_ctrl: once-per-frame bounce scheduler for NUM_SPRITES QR sprites, updated during vertical blanking.
module qr_motion_ctrl #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int SPRITE_SIZE = 54,
  parameter int NUM_SPRITES = 2,
  parameter int IDW         = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    vblank_start,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [IDW-1:0]          cfg_id,
  input  logic [3:0]              cfg_step_x,
  input  logic [3:0]              cfg_step_y,
  input  logic [3:0]              cfg_period,
  input  logic                    cfg_en,
  input  logic                    cfg_load_pos,
  input  logic [9:0]              cfg_x,
  input  logic [9:0]              cfg_y,
  output logic [10*NUM_SPRITES-1:0] pos_x,
  output logic [10*NUM_SPRITES-1:0] pos_y,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    overrun
);
  localparam logic [9:0] XMAX = 10'(H_RES - SPRITE_SIZE);
  localparam logic [9:0] YMAX = 10'(V_RES - SPRITE_SIZE);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state, state_n;
  logic pending, pend_n, ovr_n, done_q, accept, last;
  logic [IDW-1:0] idx;
  logic [9:0] px [NUM_SPRITES];
  logic [9:0] py [NUM_SPRITES];
  logic [3:0] sx [NUM_SPRITES];
  logic [3:0] sy [NUM_SPRITES];
  logic [3:0] per [NUM_SPRITES];
  logic [3:0] fcnt [NUM_SPRITES];
  logic       en [NUM_SPRITES];
  logic       dx [NUM_SPRITES];
  logic       dy [NUM_SPRITES];
  // returns {dir, pos}; edges clamp exactly and flip direction
  function automatic logic [10:0] mv(input logic [9:0] p, input logic d, input logic [3:0] s, input logic [9:0] mx);
    logic [10:0] sum;
    sum = {1'b0, p} + {7'd0, s};
    if (s == 4'd0) return {d, p};
    if (d) return (sum >= {1'b0, mx}) ? {1'b0, mx} : {1'b1, sum[9:0]};
    return (p <= {6'd0, s}) ? {1'b1, 10'd0} : {1'b0, p - {6'd0, s}};
  endfunction
  assign cfg_ready  = (state == IDLE);
  assign accept     = cfg_valid && cfg_ready;
  assign last       = (idx == IDW'(NUM_SPRITES - 1));
  assign frame_done = done_q;
  assign busy       = (state != IDLE) || done_q;
  always_comb begin
    state_n = state;
    pend_n  = pending;
    ovr_n   = overrun;
    if (state == IDLE) begin
      if (accept && vblank_start) begin
        pend_n = 1'b1;
        ovr_n  = overrun | pending;
      end else if (pending) begin
        state_n = SCAN;
        pend_n  = vblank_start;
      end else if (vblank_start) state_n = SCAN;
    end else begin
      if (vblank_start) begin
        pend_n = 1'b1;
        ovr_n  = overrun | pending;
      end
      state_n = (state == DONE) ? IDLE : (last ? DONE : SCAN);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pending <= 1'b0;
      overrun <= 1'b0;
      done_q  <= 1'b0;
      idx     <= '0;
    end else begin
      state   <= state_n;
      pending <= pend_n;
      overrun <= ovr_n;
      done_q  <= (state == DONE);
      idx     <= (state == SCAN) ? idx + 1'b1 : '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        px[i] <= '0; py[i] <= '0; dx[i] <= 1'b1; dy[i] <= 1'b1;
        sx[i] <= 4'd1; sy[i] <= 4'd1; per[i] <= '0; fcnt[i] <= '0; en[i] <= 1'b1;
      end
    end else if (accept && int'(cfg_id) < NUM_SPRITES) begin
      sx[cfg_id]   <= cfg_step_x;
      sy[cfg_id]   <= cfg_step_y;
      per[cfg_id]  <= cfg_period;
      en[cfg_id]   <= cfg_en;
      fcnt[cfg_id] <= '0;
      if (cfg_load_pos) begin
        px[cfg_id] <= (cfg_x > XMAX) ? XMAX : cfg_x;
        py[cfg_id] <= (cfg_y > YMAX) ? YMAX : cfg_y;
        dx[cfg_id] <= 1'b1;
        dy[cfg_id] <= 1'b1;
      end
    end else if (state == SCAN && en[idx]) begin
      if (fcnt[idx] != per[idx]) fcnt[idx] <= fcnt[idx] + 4'd1;
      else begin
        fcnt[idx] <= '0;
        {dx[idx], px[idx]} <= mv(px[idx], dx[idx], sx[idx], XMAX);
        {dy[idx], py[idx]} <= mv(py[idx], dy[idx], sy[idx], YMAX);
      end
    end
  end
  always_comb begin
    pos_x = '0;
    pos_y = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      pos_x[10*i +: 10] = px[i];
      pos_y[10*i +: 10] = py[i];
    end
  end
endmodule
